// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin, wormhole-locked output arbiter for one NOC router
// output port, with a single-entry registered output stage.
//
// Ports:
//   clk               clock, rising-edge active
//   reset             asynchronous, active-low reset
//   valid_i[N]        per-input flit valid
//   tail_i[N]         per-input tail marker (qualified by valid_i)
//   data_i[N*DW]      per-input payload, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ready_o[N]        per-input accept (only the owner, only while locked)
//   priority_order_i  one-hot search start from the priority register
//   change_order_o    one-cycle rotate request to the priority register
//   valid_o/data_o/tail_o  registered output flit
//   ready_i           downstream accept
//   grant_o[N]        one-hot current owner, zero when unlocked
module rr_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_PORTS-1:0]            valid_i,
  input  logic [N_PORTS-1:0]            tail_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0] data_i,
  output logic [N_PORTS-1:0]            ready_o,
  input  logic [N_PORTS-1:0]            priority_order_i,
  output logic                          change_order_o,
  output logic                          valid_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          tail_o,
  input  logic                          ready_i,
  output logic [N_PORTS-1:0]            grant_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    ROTATE = 2'd2
  } state_t;

  state_t                  state;
  logic [N_PORTS-1:0]      grant_q;
  logic                    change_q;

  logic                    vld_p0;
  logic                    tail_p0;
  logic [DATA_WIDTH-1:0]   data_p0;

  logic                    out_free;
  logic                    xfer;
  logic                    owner_valid;
  logic                    owner_tail;
  logic [DATA_WIDTH-1:0]   owner_data;
  logic [N_PORTS-1:0]      winner;

  // Wrap-around search starting at the lowest set bit of prio (bit 0 when
  // prio is all-zero, so a malformed priority still yields a grant).
  function automatic logic [N_PORTS-1:0] rr_pick(
    input logic [N_PORTS-1:0] req,
    input logic [N_PORTS-1:0] prio
  );
    logic [N_PORTS-1:0] gnt;
    logic               found;
    int                 s;
    int                 k;
    gnt   = '0;
    found = 1'b0;
    s     = 0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (prio[i]) s = i;
    end
    for (int i = 0; i < N_PORTS; i++) begin
      k = s + i;
      if (k >= N_PORTS) k = k - N_PORTS;
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
    return gnt;
  endfunction

  // Owner view of the inputs; grant_q is one-hot or zero, so OR-muxing is safe.
  always_comb begin
    owner_data = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (grant_q[k]) owner_data = owner_data | data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign owner_valid = |(valid_i & grant_q);
  assign owner_tail  = |(tail_i & valid_i & grant_q);
  assign winner      = rr_pick(valid_i, priority_order_i);

  // The output register can take a flit if it is empty or draining this cycle.
  assign out_free = !vld_p0 || ready_i;
  assign xfer     = (state == LOCKED) && owner_valid && out_free;
  assign ready_o  = ((state == LOCKED) && out_free) ? grant_q : '0;

  // Arbitration / lock FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      change_q <= 1'b0;
    end else begin
      change_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|valid_i) begin
            grant_q <= winner;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          // An owner that stops sending keeps the lock; only its tail frees it.
          if (xfer && owner_tail) begin
            grant_q  <= '0;
            change_q <= 1'b1;
            state    <= ROTATE;
          end
        end
        ROTATE: begin
          state <= IDLE;
        end
        default: begin
          grant_q <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Stage p0: single-entry output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      tail_p0 <= 1'b0;
      data_p0 <= '0;
    end else begin
      if (xfer) begin
        vld_p0  <= 1'b1;
        tail_p0 <= owner_tail;
        data_p0 <= owner_data;
      end else if (ready_i) begin
        vld_p0  <= 1'b0;
      end
    end
  end

  assign valid_o        = vld_p0;
  assign tail_o         = tail_p0;
  assign data_o         = data_p0;
  assign grant_o        = grant_q;
  assign change_order_o = change_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: scoreboard bench for rr_arbiter. Stimulus queues packets per
// port; a packet-level reference model predicts grant order and output flits,
// and a negedge monitor pops and compares whenever the DUT hands a flit out.
module tb_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic          tail;
    logic [DW-1:0] data;
  } flit_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    valid_i;
  logic [N-1:0]    tail_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    ready_o;
  logic [N-1:0]    priority_order_i;
  logic            change_order_o;
  logic            valid_o;
  logic [DW-1:0]   data_o;
  logic            tail_o;
  logic            ready_i;
  logic [N-1:0]    grant_o;

  rr_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_i          (valid_i),
    .tail_i           (tail_i),
    .data_i           (data_i),
    .ready_o          (ready_o),
    .priority_order_i (priority_order_i),
    .change_order_o   (change_order_o),
    .valid_o          (valid_o),
    .data_o           (data_o),
    .tail_o           (tail_o),
    .ready_i          (ready_i),
    .grant_o          (grant_o)
  );

  always #5 clk = ~clk;

  flit_t       src_q [N][$];
  flit_t       exp_q [$];
  logic [N-1:0] exp_grant [$];
  int          grant_cyc [$];
  int          grant_port [$];

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;

  logic [N-1:0] stall       = '0;
  logic [N-1:0] prio_manual = '0;
  logic [N-1:0] prio_model  = 4'b0001;
  bit           use_model   = 1'b0;
  bit           rand_ready  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference rule: start at the lowest set priority bit (0 if none), scan
  // the ports in circular order, first requester wins.
  function automatic int rr_winner(input logic [N-1:0] req, input logic [N-1:0] prio);
    int s;
    int order [$];
    int w;
    s = -1;
    for (int i = 0; i < N; i++) if (prio[i] && s < 0) s = i;
    if (s < 0) s = 0;
    for (int i = 0; i < N; i++) order.push_back((s + i) % N);
    w = -1;
    foreach (order[j]) if (w < 0 && req[order[j]]) w = order[j];
    return w;
  endfunction

  // Packet-level prediction over everything currently queued at the inputs.
  task automatic model_predict(input logic [N-1:0] prio_start, input bit rotate);
    int           idx [N];
    logic [N-1:0] prio;
    logic [N-1:0] req;
    int           w;
    flit_t        f;
    prio = prio_start;
    for (int k = 0; k < N; k++) idx[k] = 0;
    for (int guard = 0; guard < 64; guard++) begin
      for (int k = 0; k < N; k++) req[k] = (idx[k] < src_q[k].size());
      if (req == '0) break;
      w = rr_winner(req, prio);
      exp_grant.push_back(N'(1) << w);
      do begin
        f = src_q[w][idx[w]];
        idx[w]++;
        exp_q.push_back(f);
      end while (!f.tail);
      if (rotate) prio = {prio[0], prio[N-1:1]};
    end
  endtask

  task automatic add_packet(input int port, input int len, input logic [DW-1:0] base, input bit rnd);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f.data = rnd ? DW'($urandom) : base + DW'(i);
      f.tail = (i == len - 1);
      src_q[port].push_back(f);
    end
  endtask

  task automatic apply_inputs();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        valid_i[k]            = !stall[k];
        tail_i[k]             = src_q[k][0].tail;
        data_i[k*DW +: DW]    = src_q[k][0].data;
      end else begin
        valid_i[k]            = 1'b0;
        tail_i[k]             = 1'b0;
        data_i[k*DW +: DW]    = '0;
      end
    end
    priority_order_i = use_model ? prio_model : prio_manual;
    if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
  endtask

  // One clock: capture handshakes before the edge, advance sources after it.
  task automatic step();
    logic [N-1:0] hs;
    logic         co;
    @(negedge clk);
    hs = valid_i & ready_o;
    co = change_order_o;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    if (co) prio_model = {prio_model[0], prio_model[N-1:1]};
    apply_inputs();
  endtask

  task automatic flush_all();
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    exp_grant.delete();
  endtask

  function automatic bit busy();
    bit b;
    b = (exp_q.size() > 0) || (exp_grant.size() > 0) || (grant_o != '0) || valid_o || change_order_o;
    for (int k = 0; k < N; k++) if (src_q[k].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while (busy() && n < max) begin
      step();
      n++;
    end
    check({name, "_drained"}, 64'(busy()), 64'd0);
    check({name, "_scoreboard_left"}, 64'(exp_q.size() + exp_grant.size()), 64'd0);
    flush_all();
  endtask

  task automatic wait_grant(input string name, input logic [N-1:0] g, input int max);
    int n;
    n = 0;
    while (grant_o !== g && n < max) begin
      step();
      n++;
    end
    check(name, 64'(grant_o), 64'(g));
  endtask

  // Monitor: scoreboard pops, rotate-pulse timing, grant order, invariants.
  flit_t       mon_f;
  logic        prev_ths = 1'b0;
  logic [N-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_ths <= 1'b0;
      prev_gnt <= '0;
    end else begin
      if (valid_o && ready_i) begin
        check("flit_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_f = exp_q.pop_front();
          check("flit_data", 64'(data_o), 64'(mon_f.data));
          check("flit_tail", 64'(tail_o), 64'(mon_f.tail));
        end
      end
      check("change_order_after_tail", 64'(change_order_o), 64'(prev_ths));
      check("grant_ready_invariant",
            64'(((grant_o & (grant_o - 4'd1)) != '0) || ((ready_o & ~grant_o) != '0)), 64'd0);
      if (grant_o != '0 && prev_gnt == '0) begin
        grant_cyc.push_back(cyc);
        grant_port.push_back(onehot_idx(grant_o));
        check("grant_expected", 64'(exp_grant.size() > 0), 64'd1);
        if (exp_grant.size() > 0) check("grant_order", 64'(grant_o), 64'(exp_grant.pop_front()));
      end
      prev_ths <= |(valid_i & ready_o & tail_i);
      prev_gnt <= grant_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int exp_ord [5];
    exp_ord = '{0, 3, 2, 1, 0};

    reset            = 1'b0;
    ready_i          = 1'b1;
    valid_i          = '0;
    tail_i           = '0;
    data_i           = '0;
    priority_order_i = '0;

    // Reset state
    step();
    step();
    check("reset_outputs", {grant_o, valid_o, tail_o, data_o, change_order_o, ready_o}, 64'd0);
    reset = 1'b1;
    step();
    check("post_reset_idle", 64'({grant_o, change_order_o}), 64'd0);

    // Search with wrap: prio 0100, requests 1011 -> port 3, then wrap to port 0
    prio_manual = 4'b0100;
    add_packet(0, 1, 32'h0000_0100, 1'b1);
    add_packet(1, 1, 32'h0000_0110, 1'b1);
    add_packet(3, 1, 32'h0000_0130, 1'b1);
    model_predict(prio_manual, 1'b0);
    apply_inputs();
    step();
    check("search_first", 64'(grant_o), 64'(4'b1000));
    wait_grant("search_wrap", 4'b0001, 10);
    drain("search", 100);

    // Wormhole hold: port 1 three flits with all others requesting
    prio_manual = 4'b0010;
    add_packet(1, 3, 32'h0000_00A1, 1'b0);
    add_packet(0, 1, 32'h0, 1'b1);
    add_packet(2, 1, 32'h0, 1'b1);
    add_packet(3, 1, 32'h0, 1'b1);
    model_predict(prio_manual, 1'b0);
    apply_inputs();
    step();
    check("worm_grant", 64'(grant_o), 64'(4'b0010));
    check("worm_ready0", 64'(ready_o), 64'(4'b0010));
    step();
    check("worm_flit1", 64'({valid_o, data_o}), {31'd0, 1'b1, 32'h0000_00A1});
    check("worm_ready1", 64'(ready_o), 64'(4'b0010));
    step();
    check("worm_flit2", 64'({valid_o, data_o}), {31'd0, 1'b1, 32'h0000_00A2});
    check("worm_ready2", 64'(ready_o), 64'(4'b0010));
    step();
    check("worm_flit3", 64'({valid_o, tail_o, data_o}), {30'd0, 2'b11, 32'h0000_00A3});
    check("worm_unlock", 64'({grant_o, change_order_o}), 64'({4'b0000, 1'b1}));
    drain("worm", 100);

    // Backpressure: hold ready_i low for 3 cycles after the first flit
    prio_manual = 4'b0001;
    add_packet(2, 3, 32'h0000_00A1, 1'b0);
    model_predict(prio_manual, 1'b0);
    apply_inputs();
    step();
    check("bp_grant", 64'(grant_o), 64'(4'b0100));
    step();
    check("bp_first", 64'({valid_o, data_o}), {31'd0, 1'b1, 32'h0000_00A1});
    ready_i = 1'b0;
    #1;
    check("bp_ready_drop", 64'(ready_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", 64'({valid_o, data_o, ready_o}), {27'd0, 1'b1, 32'h0000_00A1, 4'b0000});
    end
    ready_i = 1'b1;
    drain("bp", 100);

    // Stalled owner keeps the lock
    prio_manual = 4'b0001;
    add_packet(0, 3, 32'h0000_00D1, 1'b0);
    add_packet(3, 1, 32'h0000_00E0, 1'b0);
    model_predict(prio_manual, 1'b0);
    apply_inputs();
    step();
    check("stall_grant", 64'(grant_o), 64'(4'b0001));
    step();
    check("stall_first", 64'({valid_o, data_o}), {31'd0, 1'b1, 32'h0000_00D1});
    stall[0] = 1'b1;
    apply_inputs();
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold_grant", 64'(grant_o), 64'(4'b0001));
      check("stall_other_ready", 64'(ready_o & 4'b1110), 64'd0);
    end
    stall = '0;
    apply_inputs();
    drain("stall", 100);

    // Malformed priority: all-zero starts at 0, multi-hot at lowest set bit
    prio_manual = 4'b0000;
    add_packet(1, 1, 32'h0, 1'b1);
    add_packet(2, 1, 32'h0, 1'b1);
    model_predict(prio_manual, 1'b0);
    apply_inputs();
    step();
    check("prio_zero", 64'(grant_o), 64'(4'b0010));
    drain("prio_zero", 100);
    prio_manual = 4'b1010;
    add_packet(0, 1, 32'h0, 1'b1);
    add_packet(2, 1, 32'h0, 1'b1);
    model_predict(prio_manual, 1'b0);
    apply_inputs();
    step();
    check("prio_multi", 64'(grant_o), 64'(4'b0100));
    drain("prio_multi", 100);

    // Asynchronous reset mid-packet
    prio_manual = 4'b0001;
    add_packet(0, 3, 32'h0000_00B1, 1'b0);
    model_predict(prio_manual, 1'b0);
    apply_inputs();
    step();
    step();
    check("rst_pre_valid", 64'({valid_o, grant_o}), 64'({1'b1, 4'b0001}));
    #2;
    reset      = 1'b0;
    prio_model = 4'b0001;
    #1;
    check("rst_async_outputs", {grant_o, valid_o, tail_o, data_o, change_order_o, ready_o}, 64'd0);
    flush_all();
    apply_inputs();
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_no_rotate", 64'({change_order_o, grant_o}), 64'd0);
    end

    // Rotation fairness against the modelled priority register
    use_model = 1'b1;
    grant_cyc.delete();
    grant_port.delete();
    for (int k = 0; k < N; k++) begin
      add_packet(k, 1, 32'hF000_0000 + DW'(k * 16), 1'b0);
      add_packet(k, 1, 32'hF000_0001 + DW'(k * 16), 1'b0);
    end
    model_predict(prio_model, 1'b1);
    apply_inputs();
    drain("fair", 200);
    check("fair_grants", 64'(grant_port.size()), 64'd8);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_port.size()) check("fair_port", 64'(grant_port[i]), 64'(exp_ord[i]));
    end
    for (int i = 1; i < grant_cyc.size(); i++) begin
      check("fair_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd3);
    end

    // Randomised traffic with random downstream stalls
    rand_ready = 1'b1;
    for (int round = 0; round < 6; round++) begin
      use_model   = (round % 2 == 0);
      prio_manual = 4'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) add_packet(k, $urandom_range(1, 4), 32'h0, 1'b1);
      end
      model_predict(use_model ? prio_model : prio_manual, use_model);
      apply_inputs();
      drain("random", 600);
    end
    rand_ready = 1'b0;
    ready_i    = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
